mem_arb_seq: RTL and testbench

Sequential, parametrised memory controller between the CPU's requesters (MEM stage, IF stage, further ports) and the byte-wide RAM bus. Arbitrates NCH channels by fixed priority, then serially performs a 1-, 2- or 4-byte little-endian read or write of the granted request. Returns assembled read data with a one-cycle done pulse. Drives per-channel stall requests to the stall controller.

---
 rtl/mem_arb_seq.sv | 169 ++++++++++++++++
 tb/tb_mem_arb_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_seq.sv
// mem_arb_seq: fixed-priority arbiter plus serial byte-wide memory sequencer.
// Grants the lowest-indexed requesting channel, then moves 1, 2 or 4 bytes
// little-endian over the RAM bus and pulses done_o for the granted channel.
// The RAM is expected to return read data combinationally for the address
// currently presented on mem_a, so a byte is captured one edge after issue.
module mem_arb_seq #(
    parameter int ADDR_W = 32,
    parameter int NCH    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [NCH*ADDR_W-1:0] addr_i,
    input  logic [NCH*2-1:0]      len_i,
    input  logic [NCH*32-1:0]     wdata_i,
    output logic [31:0]           rdata_o,
    output logic [NCH-1:0]        done_o,
    output logic [NCH-1:0]        stall_o,
    output logic [ADDR_W-1:0]     mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [CW-1:0]     ch;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [2:0]        n_r;
    logic [31:0]       wdata_r;
    logic [2:0]        ic;
    logic [2:0]        rc;
    logic              pend;
    logic [31:0]       rd_buf;
    logic              wr_r;

    logic              gnt_any;
    logic [CW-1:0]     gnt_ch;
    logic [NCH-1:0]    ch_mask;

    // Byte count for a size code; code 3 is treated as a full word.
    function automatic logic [2:0] len_to_n(input logic [1:0] l);
        case (l)
            2'd0:    len_to_n = 3'd1;
            2'd1:    len_to_n = 3'd2;
            default: len_to_n = 3'd4;
        endcase
    endfunction

    // Fixed priority: scanning downwards leaves the lowest requesting index.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_any = 1'b1;
                gnt_ch  = CW'(i);
            end
        end
    end

    // One-hot view of the latched channel, used for the done pulse.
    always_comb begin
        ch_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_mask[i] = (ch == CW'(i));
        end
    end

    // Main sequencer: grant, serial byte transfer, completion pulse.
    // With rdy low everything freezes, except that an in-flight read byte is
    // forgotten (pend cleared, ic rewound) so it gets reissued afterwards.
    // Writes need no rewind: the held byte is committed once rdy returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ch       <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            n_r      <= 3'd0;
            wdata_r  <= '0;
            ic       <= 3'd0;
            rc       <= 3'd0;
            pend     <= 1'b0;
            rd_buf   <= '0;
            wr_r     <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            rdata_o  <= '0;
            done_o   <= '0;
        end else if (!rdy) begin
            pend <= 1'b0;
            if (state == S_XFER && !we_r) begin
                ic <= rc;
            end
        end else begin
            done_o <= '0;
            case (state)
                S_IDLE: begin
                    wr_r <= 1'b0;
                    if (gnt_any) begin
                        ch      <= gnt_ch;
                        we_r    <= we_i[gnt_ch];
                        addr_r  <= addr_i[gnt_ch*ADDR_W +: ADDR_W];
                        n_r     <= len_to_n(len_i[gnt_ch*2 +: 2]);
                        wdata_r <= wdata_i[gnt_ch*32 +: 32];
                        ic      <= 3'd0;
                        rc      <= 3'd0;
                        pend    <= 1'b0;
                        rd_buf  <= '0;
                        state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (we_r) begin
                        mem_a    <= addr_r + ADDR_W'(ic);
                        mem_dout <= wdata_r[ic[1:0]*8 +: 8];
                        wr_r     <= 1'b1;
                        ic       <= ic + 3'd1;
                        if (ic == n_r - 3'd1) begin
                            state <= S_DONE;
                        end
                    end else begin
                        wr_r <= 1'b0;
                        if (ic < n_r) begin
                            mem_a <= addr_r + ADDR_W'(ic);
                            ic    <= ic + 3'd1;
                            pend  <= 1'b1;
                        end else begin
                            pend  <= 1'b0;
                        end
                        if (pend) begin
                            rd_buf[rc[1:0]*8 +: 8] <= mem_din;
                            rc <= rc + 3'd1;
                            if (rc + 3'd1 == n_r) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    wr_r    <= 1'b0;
                    pend    <= 1'b0;
                    done_o  <= ch_mask;
                    rdata_o <= we_r ? 32'd0 : rd_buf;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobe is gated by rdy so the RAM never commits while the block is frozen.
    assign mem_wr = wr_r & rdy;

    // A requester stays stalled until its own done pulse releases it.
    assign stall_o = rst ? '0 : (req_i & ~done_o);

endmodule

// File: tb/tb_mem_arb_seq.sv
// tb_mem_arb_seq: directed test of mem_arb_seq with a byte RAM model that
// returns read data combinationally for the address on mem_a.
module tb_mem_arb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] addr_i;
    logic [3:0]  len_i;
    logic [63:0] wdata_i;
    logic [31:0] rdata_o;
    logic [1:0]  done_o;
    logic [1:0]  stall_o;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    logic [7:0]  ram [0:4095];
    logic        pl_en;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;

    int checks = 0;
    int passed = 0;

    mem_arb_seq #(.ADDR_W(32), .NCH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .len_i(len_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
        .stall_o(stall_o), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // RAM model: preload port for the bench, otherwise commit DUT writes.
    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    assign mem_din = ram[mem_a[11:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic set_ch(input int c, input logic we, input logic [31:0] a,
                          input logic [1:0] l, input logic [31:0] wd);
        we_i[c]          = we;
        addr_i[c*32 +: 32] = a;
        len_i[c*2 +: 2]  = l;
        wdata_i[c*32 +: 32] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; req_i = 2'b00; we_i = 2'b00;
        addr_i = '0; len_i = '0; wdata_i = '0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        tick();
        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h010, 8'h5A);
        preload(12'h200, 8'h01); preload(12'h201, 8'h02);
        preload(12'hFFF, 8'hA1); preload(12'h000, 8'hB2);
        preload(12'h001, 8'hC3); preload(12'h002, 8'hD4);
        preload(12'h300, 8'h10); preload(12'h301, 8'h20);
        preload(12'h302, 8'h30); preload(12'h303, 8'h40);
        preload(12'h040, 8'h00); preload(12'h020, 8'h00); preload(12'h021, 8'h00);
        req_i = 2'b01;
        #1;
        checks++; if (stall_o !== 2'b00) $display("[TB] FAIL rst_stall: got %b expected 00", stall_o); else passed++;
        checks++; if (mem_a !== 32'd0) $display("[TB] FAIL rst_mem_a: got %h expected 0", mem_a); else passed++;
        checks++; if (mem_wr !== 1'b0 || mem_dout !== 8'd0) $display("[TB] FAIL rst_mem_wr_dout: got %b/%h expected 0/00", mem_wr, mem_dout); else passed++;
        checks++; if (done_o !== 2'b00 || rdata_o !== 32'd0) $display("[TB] FAIL rst_done_rdata: got %b/%h expected 00/0", done_o, rdata_o); else passed++;
        req_i = 2'b00;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read4();
        logic [1:0] exp_done;
        set_ch(1, 1'b0, 32'h100, 2'd2, 32'h0);
        req_i = 2'b10;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) begin
                checks++; if (mem_a !== 32'h100 + 32'(k - 1)) $display("[TB] FAIL rd4_addr%0d: got %h expected %h", k, mem_a, 32'h100 + 32'(k - 1)); else passed++;
            end
            exp_done = (k == 6) ? 2'b10 : 2'b00;
            checks++; if (done_o !== exp_done) $display("[TB] FAIL rd4_done_c%0d: got %b expected %b", k, done_o, exp_done); else passed++;
            if (k == 3) begin
                checks++; if (stall_o !== 2'b10) $display("[TB] FAIL rd4_stall: got %b expected 10", stall_o); else passed++;
            end
        end
        checks++; if (rdata_o !== 32'h44332211) $display("[TB] FAIL rd4_rdata: got %h expected 44332211", rdata_o); else passed++;
        checks++; if (stall_o !== 2'b00) $display("[TB] FAIL rd4_stall_release: got %b expected 00", stall_o); else passed++;
        req_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_write2();
        set_ch(0, 1'b1, 32'h20, 2'd1, 32'hAABBCCDD);
        req_i = 2'b01;
        tick();
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h20 || mem_dout !== 8'hDD) $display("[TB] FAIL wr2_byte0: got %b/%h/%h expected 1/00000020/dd", mem_wr, mem_a, mem_dout); else passed++;
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h21 || mem_dout !== 8'hCC) $display("[TB] FAIL wr2_byte1: got %b/%h/%h expected 1/00000021/cc", mem_wr, mem_a, mem_dout); else passed++;
        checks++; if (done_o !== 2'b00) $display("[TB] FAIL wr2_early_done: got %b expected 00", done_o); else passed++;
        tick();
        checks++; if (mem_wr !== 1'b0) $display("[TB] FAIL wr2_wr_off: got %b expected 0", mem_wr); else passed++;
        checks++; if (done_o !== 2'b01 || rdata_o !== 32'd0) $display("[TB] FAIL wr2_done: got %b/%h expected 01/0", done_o, rdata_o); else passed++;
        checks++; if (ram[12'h020] !== 8'hDD || ram[12'h021] !== 8'hCC) $display("[TB] FAIL wr2_ram: got %h %h expected dd cc", ram[12'h020], ram[12'h021]); else passed++;
        we_i[0] = 1'b0;
        req_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_priority();
        logic [1:0] exp_done;
        set_ch(0, 1'b0, 32'h10, 2'd0, 32'h0);
        set_ch(1, 1'b0, 32'h200, 2'd1, 32'h0);
        req_i = 2'b11;
        tick();
        tick();
        checks++; if (mem_a !== 32'h10 || stall_o !== 2'b11) $display("[TB] FAIL pri_first: got %h/%b expected 00000010/11", mem_a, stall_o); else passed++;
        tick();
        checks++; if (stall_o !== 2'b11) $display("[TB] FAIL pri_stall_c2: got %b expected 11", stall_o); else passed++;
        tick();
        checks++; if (done_o !== 2'b01 || rdata_o !== 32'h5A || stall_o !== 2'b10) $display("[TB] FAIL pri_ch0_done: got %b/%h/%b expected 01/0000005a/10", done_o, rdata_o, stall_o); else passed++;
        req_i = 2'b10;
        for (int k = 4; k <= 8; k++) begin
            tick();
            if (k == 5) begin
                checks++; if (mem_a !== 32'h200) $display("[TB] FAIL pri_ch1_addr: got %h expected 00000200", mem_a); else passed++;
            end
            exp_done = (k == 8) ? 2'b10 : 2'b00;
            checks++; if (done_o !== exp_done) $display("[TB] FAIL pri_done_c%0d: got %b expected %b", k, done_o, exp_done); else passed++;
        end
        checks++; if (rdata_o !== 32'h0201) $display("[TB] FAIL pri_ch1_rdata: got %h expected 00000201", rdata_o); else passed++;
        req_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [0:3];
        exp_a[0] = 32'hFFFF_FFFF; exp_a[1] = 32'h0; exp_a[2] = 32'h1; exp_a[3] = 32'h2;
        set_ch(1, 1'b0, 32'hFFFF_FFFF, 2'd3, 32'h0);
        req_i = 2'b10;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4) begin
                checks++; if (mem_a !== exp_a[k-1]) $display("[TB] FAIL wrap_addr%0d: got %h expected %h", k, mem_a, exp_a[k-1]); else passed++;
            end
        end
        checks++; if (done_o !== 2'b10 || rdata_o !== 32'hD4C3B2A1) $display("[TB] FAIL wrap_done: got %b/%h expected 10/d4c3b2a1", done_o, rdata_o); else passed++;
        req_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_rdy();
        set_ch(0, 1'b0, 32'h300, 2'd2, 32'h0);
        req_i = 2'b01;
        tick();
        tick();
        tick();
        checks++; if (mem_a !== 32'h301) $display("[TB] FAIL rdy_byte1: got %h expected 00000301", mem_a); else passed++;
        rdy = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            checks++; if (mem_a !== 32'h301 || mem_wr !== 1'b0 || done_o !== 2'b00) $display("[TB] FAIL rdy_frozen_c%0d: got %h/%b/%b expected 00000301/0/00", k, mem_a, mem_wr, done_o); else passed++;
        end
        rdy = 1'b1;
        tick();
        checks++; if (mem_a !== 32'h301) $display("[TB] FAIL rdy_reissue: got %h expected 00000301", mem_a); else passed++;
        tick();
        tick();
        checks++; if (mem_a !== 32'h303) $display("[TB] FAIL rdy_byte3: got %h expected 00000303", mem_a); else passed++;
        tick();
        checks++; if (done_o !== 2'b00) $display("[TB] FAIL rdy_early_done: got %b expected 00", done_o); else passed++;
        tick();
        checks++; if (done_o !== 2'b01 || rdata_o !== 32'h40302010) $display("[TB] FAIL rdy_done: got %b/%h expected 01/40302010", done_o, rdata_o); else passed++;
        req_i = 2'b00;
        tick();
        // Write held across a frozen cycle must commit exactly when rdy returns.
        set_ch(0, 1'b1, 32'h40, 2'd0, 32'h77);
        req_i = 2'b01;
        tick();
        tick();
        checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h40 || mem_dout !== 8'h77) $display("[TB] FAIL rdyw_issue: got %b/%h/%h expected 1/00000040/77", mem_wr, mem_a, mem_dout); else passed++;
        rdy = 1'b0;
        #1;
        checks++; if (mem_wr !== 1'b0) $display("[TB] FAIL rdyw_forced_low: got %b expected 0", mem_wr); else passed++;
        tick();
        checks++; if (ram[12'h040] !== 8'h00 || done_o !== 2'b00) $display("[TB] FAIL rdyw_no_commit: got %h/%b expected 00/00", ram[12'h040], done_o); else passed++;
        rdy = 1'b1;
        tick();
        checks++; if (ram[12'h040] !== 8'h77 || done_o !== 2'b01) $display("[TB] FAIL rdyw_commit: got %h/%b expected 77/01", ram[12'h040], done_o); else passed++;
        we_i[0] = 1'b0;
        req_i = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_done;
        set_ch(1, 1'b0, 32'h100, 2'd2, 32'h0);
        req_i = 2'b10;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++; if (mem_a !== 32'd0 || mem_wr !== 1'b0 || mem_dout !== 8'd0) $display("[TB] FAIL rstm_mem: got %h/%b/%h expected 0/0/00", mem_a, mem_wr, mem_dout); else passed++;
        checks++; if (done_o !== 2'b00 || stall_o !== 2'b00 || rdata_o !== 32'd0) $display("[TB] FAIL rstm_outs: got %b/%b/%h expected 00/00/0", done_o, stall_o, rdata_o); else passed++;
        rst = 1'b0;
        #1;
        checks++; if (stall_o !== 2'b10) $display("[TB] FAIL rstm_stall_back: got %b expected 10", stall_o); else passed++;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (mem_a !== 32'h100) $display("[TB] FAIL rstm_regrant_addr: got %h expected 00000100", mem_a); else passed++;
            end
            exp_done = (k == 6) ? 2'b10 : 2'b00;
            checks++; if (done_o !== exp_done) $display("[TB] FAIL rstm_done_c%0d: got %b expected %b", k, done_o, exp_done); else passed++;
        end
        checks++; if (rdata_o !== 32'h44332211) $display("[TB] FAIL rstm_rdata: got %h expected 44332211", rdata_o); else passed++;
        req_i = 2'b00;
        tick();
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_read4();
        test_write2();
        test_priority();
        test_wrap();
        test_rdy();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
